control_fsm: RTL
================

# control_fsm

Multi-cycle control unit for the RV32I core; replaces the single-cycle combinational opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with a shared instruction/data memory port of variable latency. It emits the datapath control strobes and flags illegal opcodes and memory timeouts. Parameters add optional JALR support and a configurable bus timeout.

## Interface
- SUPPORT_JALR, 1, decode opcode 1100111 (JALR); when 0 it is illegal
- TIMEOUT, 64, max cycles waiting for mem_ready per access; 0 disables timeout
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous and active-high
- opcode  in  7  instruction register [6:0], valid from DECODE onward
- br_taken  in  1  ALU compare result, sampled in EXEC
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access request (FETCH, MEM)
- mem_ifetch  out  1  access is instruction fetch
- mem_we  out  1  store access
- ir_we  out  1  latch instruction and old_pc
- pc_we  out  1  update PC
- pc_src  out  2  00 pc+4, 01 old_pc+imm, 10 ALU result
- reg_write  out  1  register file write enable
- wb_pc  out  1  write-back source is PC
- mem_to_reg  out  1  write-back source is load data
- imm_data  out  1  ALU operand B is immediate
- opcode_alu  out  2  01 OP_IMM, 11 OP, 00 BRANCH, 10 add/other
- instret  out  1  one-cycle pulse per retired instruction
- illegal  out  1  sticky illegal-opcode flag
- bus_err  out  1  sticky memory-timeout flag
- state_o  out  3  current state code

## Operation
- Legal opcodes: 0010011 OP_IMM, 0110011 OP, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR (if SUPPORT_JALR). Anything else, including opcode[1:0]!=11, is illegal.
- imm_data=1 for OP_IMM, LOAD, STORE, JALR; else 0. opcode_alu per table in Interface. Decode outputs are combinational on opcode and are qualified by state only where stated.
- FETCH: mem_req=mem_ifetch=1. On mem_ready: ir_we=1, pc_we=1, pc_src=00 -> DECODE.
- DECODE: no strobes. Illegal -> TRAP and set illegal; else -> EXEC.
- EXEC: OP/OP_IMM -> WB. LOAD/STORE -> MEM. BRANCH: pc_we=br_taken, pc_src=01, instret=1 -> FETCH. JAL: reg_write=wb_pc=1, pc_we=1, pc_src=01, instret=1 -> FETCH. JALR: the same with pc_src=10. The register write captures pre-update PC (old_pc+4) on the same edge.
- MEM: mem_req=1, mem_we=(STORE). On mem_ready: STORE -> FETCH with instret=1; LOAD -> WB.
- WB: reg_write=1, mem_to_reg=(LOAD), instret=1 -> FETCH.
- TRAP: all strobes 0; held until rst. illegal/bus_err remain set.
- Wait counter: width $clog2(TIMEOUT+1), cleared on every state entry. Increments each FETCH/MEM cycle with mem_ready=0. If the counter reaches TIMEOUT with mem_ready still 0 -> TRAP and set bus_err. mem_ready on the same cycle as expiry wins (normal completion).
- mem_ready outside FETCH/MEM is ignored.

## Timing
- State codes: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.
- Reset: state FETCH, counter 0, illegal=bus_err=0. While rst=1 all outputs are 0 (state_o=0). FETCH strobes begin on the first cycle after rst deasserts.
- rst mid-instruction or in TRAP aborts on the next edge. No partial access is resumed.
- Cycles per instruction with zero-wait memory: BRANCH/JAL/JALR 3, OP/OP_IMM/STORE 4, LOAD 5. Add one cycle per wait cycle on each access.
- instret is asserted for exactly one cycle per instruction, on the retiring cycle.
- All strobes are Moore outputs except mem_ready-qualified ir_we/pc_we/instret.

## Structure
- Package ctrl_pkg: opcode constants, state enum codes, pc_src codes, opcode_alu codes.
- Sub-module opcode_decode: combinational opcode -> {legal, class, imm_data, opcode_alu}, parametrised by SUPPORT_JALR. control_fsm holds the state register, wait counter and sticky flags.

## Test plan
- OP 0110011, mem_ready always 1 -> states 0,1,2,4,0. reg_write only in WB, instret once at cycle 4, opcode_alu=11.
- LOAD with 3 wait cycles in MEM -> mem_req held 4 cycles in MEM, WB has mem_to_reg=1, total 8 cycles.
- BRANCH with br_taken=1 then 0 -> pc_we=1 with pc_src=01 in the first EXEC, pc_we=0 in the second, 3 cycles each.
- JALR with SUPPORT_JALR=0 -> TRAP after DECODE, illegal=1, strobes 0 until rst. With SUPPORT_JALR=1 -> reg_write, wb_pc, pc_src=10 in EXEC.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP, bus_err=1. mem_ready on the expiry cycle -> normal DECODE, bus_err=0.
- rst pulse during MEM of a STORE -> all outputs 0 during rst, FETCH afterwards, no instret for the aborted store.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, state codes,
// instruction classes and the datapath select codes.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } cls_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] ALU_BRANCH = 2'b00;
  localparam logic [1:0] ALU_OP_IMM = 2'b01;
  localparam logic [1:0] ALU_ADD    = 2'b10;
  localparam logic [1:0] ALU_OP     = 2'b11;

  typedef struct packed {
    logic       legal;
    cls_t       cls;
    logic       imm_data;
    logic [1:0] opcode_alu;
  } dec_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: legality, instruction class, operand-B select
// and ALU operation group.
module opcode_decode
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JALR = 1'b1
) (
  input  logic [6:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '{legal: 1'b0, cls: CLS_ILLEGAL, imm_data: 1'b0, opcode_alu: ALU_ADD};
    case (opcode)
      OPC_OP:     dec.cls = CLS_OP;
      OPC_OP_IMM: dec.cls = CLS_OP_IMM;
      OPC_LOAD:   dec.cls = CLS_LOAD;
      OPC_STORE:  dec.cls = CLS_STORE;
      OPC_BRANCH: dec.cls = CLS_BRANCH;
      OPC_JAL:    dec.cls = CLS_JAL;
      OPC_JALR:   dec.cls = SUPPORT_JALR ? CLS_JALR : CLS_ILLEGAL;
      default:    dec.cls = CLS_ILLEGAL;
    endcase

    dec.legal    = (dec.cls != CLS_ILLEGAL);
    dec.imm_data = (dec.cls == CLS_OP_IMM) || (dec.cls == CLS_LOAD) ||
                   (dec.cls == CLS_STORE)  || (dec.cls == CLS_JALR);

    case (dec.cls)
      CLS_OP_IMM: dec.opcode_alu = ALU_OP_IMM;
      CLS_OP:     dec.opcode_alu = ALU_OP;
      CLS_BRANCH: dec.opcode_alu = ALU_BRANCH;
      default:    dec.opcode_alu = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory port, bus timeout and sticky fault flags.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JALR = 1'b1,
  parameter int TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_ifetch,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       wb_pc,
  output logic       mem_to_reg,
  output logic       imm_data,
  output logic [1:0] opcode_alu,
  output logic       instret,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);

  localparam int             CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);
  localparam bit             TO_EN = (TIMEOUT > 0);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          illegal_q, bus_err_q;
  logic          waiting, expired;
  dec_t          dec;

  opcode_decode #(.SUPPORT_JALR(SUPPORT_JALR)) u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  // Memory handshake: mem_req stays high for the whole FETCH/MEM state and the
  // access completes on the first cycle mem_ready is seen with mem_req high;
  // mem_ready in any other state has no effect.
  assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  assign expired = TO_EN && waiting && (cnt == TMAX);

  always_comb begin
    nxt = state;
    case (state)
      ST_FETCH:  if (mem_ready) nxt = ST_DECODE;
                 else if (expired) nxt = ST_TRAP;
      ST_DECODE: nxt = dec.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (dec.cls)
          CLS_OP, CLS_OP_IMM:  nxt = ST_WB;
          CLS_LOAD, CLS_STORE: nxt = ST_MEM;
          default:             nxt = ST_FETCH;
        endcase
      end
      ST_MEM:    if (mem_ready) nxt = (dec.cls == CLS_STORE) ? ST_FETCH : ST_WB;
                 else if (expired) nxt = ST_TRAP;
      ST_WB:     nxt = ST_FETCH;
      ST_TRAP:   nxt = ST_TRAP;
      default:   nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      cnt       <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)           cnt <= '0;
      else if (waiting && TO_EN)  cnt <= cnt + 1'b1;
      if ((state == ST_DECODE) && !dec.legal) illegal_q <= 1'b1;
      if (expired)                            bus_err_q <= 1'b1;
    end
  end

  // Strobes are Moore on state/opcode; only ir_we, pc_we and instret look at mem_ready.
  always_comb begin
    mem_req    = 1'b0;
    mem_ifetch = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    wb_pc      = 1'b0;
    mem_to_reg = 1'b0;
    instret    = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          ir_we      = mem_ready;
          pc_we      = mem_ready;
        end
        ST_EXEC: begin
          case (dec.cls)
            CLS_BRANCH: begin
              pc_we   = br_taken;
              pc_src  = PC_REL;
              instret = 1'b1;
            end
            CLS_JAL, CLS_JALR: begin
              reg_write = 1'b1;
              wb_pc     = 1'b1;
              pc_we     = 1'b1;
              pc_src    = (dec.cls == CLS_JALR) ? PC_ALU : PC_REL;
              instret   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (dec.cls == CLS_STORE);
          instret = mem_ready && (dec.cls == CLS_STORE);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (dec.cls == CLS_LOAD);
          instret    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imm_data   = !rst && dec.imm_data;
  assign opcode_alu = rst ? 2'b00 : dec.opcode_alu;
  assign illegal    = !rst && illegal_q;
  assign bus_err    = !rst && bus_err_q;
  assign state_o    = rst ? 3'd0 : state;

endmodule
